echo_processor: RTL and testbench
=================================

// Module: echo_processor
// PURPOSE
//   Single-tap echo stage between spi2adc and spi2dac/pwm. Each ADC sample
//   (10-bit offset binary) enters a circular delay buffer. Output is
//   y[n] = x[n]/2 + x[n-D]/2, where delay D is set from the slide switches.
//   Drop-in replacement for the all-pass processor; drives data_out to the DAC.
// PARAMETERS
//   ADDR_W      13  delay buffer address width; depth = 2**ADDR_W samples (8192)
//   DELAY_SHIFT  3  D = var_in << DELAY_SHIFT (10-bit SW -> 0..8184 samples)
// PORTS
//   sysclk      in   1   50 MHz system clock
//   reset       in   1   synchronous, active-high reset
//   data_in     in  10   ADC sample, offset binary (512 = 0 V mid-rail)
//   data_valid  in   1   1-cycle pulse: data_in holds a new sample
//   var_in      in  10   delay select from SW[9:0]
//   data_out    out 10   processed sample, offset binary; held between updates
//   out_valid   out  1   1-cycle pulse when data_out updates
//   busy        out  1   high while FSM is not in IDLE
// BEHAVIOUR
//   Reset (sync, sysclk edge with reset=1): data_out=10'd512, out_valid=0,
//     busy=0, wr_ptr=0, fill_cnt=0, FSM->IDLE. Buffer RAM is NOT cleared;
//     fill_cnt masks stale contents.
//   Format: x = {~data_in[9], data_in[8:0]} (signed 2's complement). Output
//     converts back the same way: data_out = {~y[9], y[8:0]}.
//   FSM:
//     IDLE : if data_valid -> latch x_r=x, D_r=var_in<<DELAY_SHIFT;
//            rd_addr = wr_ptr - D_r (mod 2**ADDR_W) -> READ. Else stay.
//     READ : synchronous RAM read in flight -> CALC.
//     CALC : d = (fill_cnt >= D_r && D_r != 0) ? ram_q : 0;
//            if D_r==0: y = x_r (bypass, no halving)
//            else y = (x_r>>>1) + (d>>>1) (arithmetic shift, truncate toward -inf)
//            -> WRITE.
//     WRITE: ram[wr_ptr] <= x_r; wr_ptr <= wr_ptr+1 (wraps 2**ADDR_W-1 -> 0);
//            fill_cnt <= sat(fill_cnt+1) at 2**ADDR_W-1; data_out <= y;
//            out_valid=1 for this cycle -> IDLE.
//   Latency: out_valid is asserted 4 sysclk cycles after the data_valid edge
//     (IDLE->READ->CALC->WRITE, registered output). At 10 kHz sampling the
//     FSM is idle for more than 99.9% of the time.
//   Sum width: two 10-bit halves cannot overflow; no saturation is needed.
//   data_valid while busy=1: ignored (sample dropped). wr_ptr and fill_cnt
//     are unchanged.
//   var_in is sampled only at IDLE acceptance. Changing it mid-operation
//     has no effect on the current sample.
//   Read-before-write on same address (D = 2**ADDR_W, unreachable at
//     default params): the read returns old contents.
//   Reset asserted mid-operation: FSM aborts to IDLE. No out_valid is
//     issued for the aborted sample, and no RAM write occurs.
//   Single clock domain; all inputs are already synchronous to sysclk.
// TESTING
//   1 Reset, var_in=0, feed data_in=700 -> data_out=700, out_valid pulses
//     exactly 4 cycles after data_valid (bypass).
//   2 var_in=1 (D=8), impulse 1023 then 512 x20 -> outputs 767 (first),
//     512 x7, 767 at 9th sample (index 8), then 512.
//   3 After reset, D=8, first 8 samples = 600 -> outputs 556 (stale RAM is
//     masked to 0, x/2 only).
//   4 D=8184, run 9000 samples of a ramp (i mod 1024) -> after fill, check
//     data_out = x/2 + x[n-8184]/2 across the wr_ptr wrap at 8191->0.
//   5 Pulse data_valid on cycles t and t+2 -> only one out_valid; wr_ptr
//     advances by 1.
//   6 Assert reset in CALC -> no out_valid, data_out=512, busy=0 next cycle;
//     next sample processed normally.

Source files
------------

// File: rtl/echo_processor.sv
`default_nettype none
// ============================================================================
//  Module      : echo_processor
//  Description : Single-tap echo stage. Each accepted ADC sample is stored in
//                a circular delay buffer and the output is the average of the
//                current sample and the sample D positions earlier, where D
//                is selected from the slide switches. D = 0 bypasses.
//  Revision    : 1.0  initial release
// ============================================================================
module echo_processor #(
    parameter int ADDR_W      = 13,
    parameter int DELAY_SHIFT = 3
) (
    input  logic       sysclk,
    input  logic       reset,
    input  logic [9:0] data_in,
    input  logic       data_valid,
    input  logic [9:0] var_in,
    output logic [9:0] data_out,
    output logic       out_valid,
    output logic       busy
);

    localparam int c_DEPTH = 2 ** ADDR_W;
    localparam int c_D_W   = 10 + DELAY_SHIFT;
    localparam int c_CMP_W = (c_D_W > ADDR_W) ? c_D_W : ADDR_W;

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_READ  = 2'd1;
    localparam logic [1:0] c_ST_CALC  = 2'd2;
    localparam logic [1:0] c_ST_WRITE = 2'd3;

    localparam logic [9:0]        c_MID_RAIL = 10'd512;
    localparam logic [ADDR_W-1:0] c_FILL_MAX = {ADDR_W{1'b1}};

    // FSM state
    logic [1:0] r_state;
    logic [1:0] w_next_state;

    // Datapath registers (no reset needed: qualified by FSM state)
    logic signed [9:0]  r_x;
    logic [c_D_W-1:0]   r_delay;
    logic [ADDR_W-1:0]  r_rd_addr;
    logic signed [9:0]  r_y;
    logic [9:0]         r_ram_q;

    // Control registers
    logic [ADDR_W-1:0]  r_wr_ptr;
    logic [ADDR_W-1:0]  r_fill_cnt;
    logic [9:0]         r_data_out;
    logic               r_out_valid;

    // Delay buffer storage; never cleared, r_fill_cnt masks stale entries
    logic [9:0]         r_ram [0:c_DEPTH-1];

    // Combinational helpers
    logic signed [9:0]  w_x_in;
    logic [c_D_W-1:0]   w_delay;
    logic               w_accept;
    logic               w_tap_valid;
    logic signed [9:0]  w_d;
    logic signed [9:0]  w_y;
    logic               w_ram_we;

    // Offset binary to two's complement is a flip of the MSB
    assign w_x_in   = $signed({~data_in[9], data_in[8:0]});
    assign w_delay  = c_D_W'(var_in) << DELAY_SHIFT;
    assign w_accept = (r_state == c_ST_IDLE) && data_valid;

    // A tap is only trusted once that many samples have really been written
    assign w_tap_valid = (r_delay != '0) &&
                         (c_CMP_W'(r_fill_cnt) >= c_CMP_W'(r_delay));
    assign w_d         = w_tap_valid ? $signed(r_ram_q) : 10'sd0;

    // Halves are each within [-256,255], so the sum cannot overflow 10 bits
    assign w_y = (r_delay == '0) ? r_x : ((r_x >>> 1) + (w_d >>> 1));

    // Reset landing on the WRITE cycle must not commit the aborted sample
    assign w_ram_we = (r_state == c_ST_WRITE) && !reset;

    assign data_out  = r_data_out;
    assign out_valid = r_out_valid;
    assign busy      = (r_state != c_ST_IDLE);

    // State register
    always_ff @(posedge sysclk) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: fixed IDLE->READ->CALC->WRITE walk per sample
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_ST_IDLE:  if (data_valid) w_next_state = c_ST_READ;
            c_ST_READ:  w_next_state = c_ST_CALC;
            c_ST_CALC:  w_next_state = c_ST_WRITE;
            c_ST_WRITE: w_next_state = c_ST_IDLE;
            default:    w_next_state = c_ST_IDLE;
        endcase
    end

    // Capture sample, delay and read address at acceptance; capture result in CALC
    always_ff @(posedge sysclk) begin
        if (w_accept) begin
            r_x       <= w_x_in;
            r_delay   <= w_delay;
            r_rd_addr <= r_wr_ptr - ADDR_W'(w_delay);
        end
        if (r_state == c_ST_CALC) begin
            r_y <= w_y;
        end
    end

    // Delay buffer: read in READ, write in WRITE (read sees old contents)
    always_ff @(posedge sysclk) begin
        if (w_ram_we) begin
            r_ram[r_wr_ptr] <= r_x;
        end
        if (r_state == c_ST_READ) begin
            r_ram_q <= r_ram[r_rd_addr];
        end
    end

    // Pointer, fill level and registered output update on WRITE
    always_ff @(posedge sysclk) begin
        if (reset) begin
            r_wr_ptr    <= '0;
            r_fill_cnt  <= '0;
            r_data_out  <= c_MID_RAIL;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
            if (r_state == c_ST_WRITE) begin
                r_wr_ptr    <= r_wr_ptr + 1'b1;
                if (r_fill_cnt != c_FILL_MAX) begin
                    r_fill_cnt <= r_fill_cnt + 1'b1;
                end
                r_data_out  <= {~r_y[9], r_y[8:0]};
                r_out_valid <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_echo_processor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_echo_processor
//  Description : Self-checking bench for echo_processor: directed table of
//                vectors, hand-written corner sequences and randomized
//                samples checked against a sample-history reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_echo_processor;

    logic       sysclk = 1'b0;
    logic       reset;
    logic [9:0] data_in;
    logic       data_valid;
    logic [9:0] var_in;
    logic [9:0] data_out;
    logic       out_valid;
    logic       busy;

    int vectors     = 0;
    int miscompares = 0;

    // Every accepted sample since reset, as a signed value
    int hist[$];

    typedef struct {
        bit rst;
        int din;
        int v;
        int exp;
    } vec_t;

    vec_t tbl[$];

    echo_processor dut (
        .sysclk     (sysclk),
        .reset      (reset),
        .data_in    (data_in),
        .data_valid (data_valid),
        .var_in     (var_in),
        .data_out   (data_out),
        .out_valid  (out_valid),
        .busy       (busy)
    );

    always #5 sysclk = ~sysclk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got hang required finish");
        $fatal(1);
    end

    task automatic check(input string name, input int got, input int exp);
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d required %0d", name, got, exp);
        end
    endtask

    // y = x/2 + x[n-D]/2 with floor halving, missing history reads as 0,
    // D = 0 passes the sample through unchanged
    function automatic int model(input int din, input int v);
        int x, d, dl, n, y;
        x  = din - 512;
        dl = v * 8;
        n  = hist.size();
        d  = (dl != 0 && n >= dl) ? hist[n - dl] : 0;
        if (dl == 0) y = x;
        else         y = (x >>> 1) + (d >>> 1);
        hist.push_back(x);
        return y + 512;
    endfunction

    task automatic do_reset();
        @(negedge sysclk);
        reset      = 1'b1;
        data_valid = 1'b0;
        @(negedge sysclk);
        reset = 1'b0;
        hist.delete();
    endtask

    task automatic run_sample(input int din, input int v, input int exp, input string tag);
        int lat;
        @(negedge sysclk);
        data_in    = din[9:0];
        var_in     = v[9:0];
        data_valid = 1'b1;
        @(negedge sysclk);
        data_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 12) begin
            @(negedge sysclk);
            lat++;
        end
        check({tag, " latency"}, lat, 4);
        check({tag, " data_out"}, int'(data_out), exp);
    endtask

    task automatic add_vec(input bit rst, input int din, input int v, input int exp);
        vec_t e;
        e.rst = rst; e.din = din; e.v = v; e.exp = exp;
        tbl.push_back(e);
    endtask

    initial begin
        int v_set[5];
        int cnt, got, exp_a, din_a, din_b;

        v_set = '{0, 1, 2, 3, 8};
        reset      = 1'b1;
        data_valid = 1'b0;
        data_in    = 10'd512;
        var_in     = 10'd0;

        // Reset state
        repeat (3) @(negedge sysclk);
        check("reset data_out", int'(data_out), 512);
        check("reset out_valid", int'(out_valid), 0);
        check("reset busy", int'(busy), 0);
        reset = 1'b0;

        // Directed vectors
        add_vec(1, 700, 0, 700);                            // bypass
        add_vec(1, 1023, 1, 767);                           // impulse, D=8
        for (int i = 0; i < 7; i++) add_vec(0, 512, 1, 512);
        add_vec(0, 512, 1, 767);                            // echo at index 8
        for (int i = 0; i < 11; i++) add_vec(0, 512, 1, 512);
        for (int i = 0; i < 8; i++) add_vec(i == 0, 600, 1, 556);  // stale RAM masked
        add_vec(0, 600, 1, 600);                            // first real tap
        add_vec(1, 0, 1, 256);                              // most negative
        add_vec(0, 1, 1, 256);                              // floor of -511/2
        add_vec(1, 0, 0, 0);                                // bypass, negative rail
        add_vec(0, 1023, 0, 1023);                          // bypass, positive rail

        foreach (tbl[i]) begin
            if (tbl[i].rst) do_reset();
            run_sample(tbl[i].din, tbl[i].v, tbl[i].exp, $sformatf("table[%0d]", i));
        end

        // Randomized samples with assorted delays
        do_reset();
        for (int i = 0; i < 400; i++) begin
            int din, v;
            din = int'($urandom_range(0, 1023));
            v   = v_set[$urandom_range(0, 4)];
            run_sample(din, v, model(din, v), "random");
        end

        // Maximum delay across the write-pointer wrap
        do_reset();
        for (int i = 0; i < 9000; i++) begin
            run_sample(i % 1024, 1023, model(i % 1024, 1023), "ramp D=8184");
        end

        // Second data_valid while busy is dropped; var_in change mid-flight ignored
        do_reset();
        for (int i = 0; i < 10; i++) begin
            int din;
            din = int'($urandom_range(0, 1023));
            run_sample(din, 1, model(din, 1), "pre-drop");
        end
        din_a = 300;
        din_b = 900;
        exp_a = model(din_a, 1);
        cnt   = 0;
        got   = -1;
        @(negedge sysclk);
        data_in = din_a[9:0]; var_in = 10'd1; data_valid = 1'b1;
        @(negedge sysclk);
        data_valid = 1'b0; var_in = 10'd0;
        check("drop busy", int'(busy), 1);
        if (out_valid) begin cnt++; got = int'(data_out); end
        @(negedge sysclk);
        data_in = din_b[9:0]; data_valid = 1'b1;
        if (out_valid) begin cnt++; got = int'(data_out); end
        @(negedge sysclk);
        data_valid = 1'b0;
        if (out_valid) begin cnt++; got = int'(data_out); end
        for (int i = 0; i < 10; i++) begin
            @(negedge sysclk);
            if (out_valid) begin cnt++; got = int'(data_out); end
        end
        check("drop out_valid count", cnt, 1);
        check("drop data_out", got, exp_a);
        for (int i = 0; i < 12; i++) begin
            int din;
            din = int'($urandom_range(0, 1023));
            run_sample(din, 1, model(din, 1), "post-drop");
        end

        // Reset during CALC aborts the sample
        do_reset();
        for (int i = 0; i < 9; i++) begin
            run_sample(100 + i * 50, 1, model(100 + i * 50, 1), "pre-abort");
        end
        @(negedge sysclk);
        data_in = 10'd1000; var_in = 10'd1; data_valid = 1'b1;
        @(negedge sysclk);
        data_valid = 1'b0;
        @(negedge sysclk);
        reset = 1'b1;
        @(negedge sysclk);
        check("abort out_valid", int'(out_valid), 0);
        check("abort data_out", int'(data_out), 512);
        check("abort busy", int'(busy), 0);
        reset = 1'b0;
        hist.delete();
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge sysclk);
            if (out_valid) cnt++;
        end
        check("abort no late out_valid", cnt, 0);
        for (int i = 0; i < 10; i++) begin
            int din;
            din = int'($urandom_range(0, 1023));
            run_sample(din, 1, model(din, 1), "post-abort");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
